// File: rtl/crf_axil_cfg_master.sv
// crf_axil_cfg_master: AXI4-Lite master that turns one valid/ready register command into one AXI-Lite transaction and returns the result on a valid/ready response port (cmd_* in, rsp_* out, m_axi_* to the slave, timeout yields resp 2'b11)
module crf_axil_cfg_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_wr,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_wr,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic wait_st, adv, tmo, aw_w_done;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign aw_w_done = (!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready);
  assign wait_st = state inside {WR_AW_W, WR_B, RD_AR, RD_R};
  assign tmo = TIMEOUT_CYCLES != 0 && cnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    adv = state == WR_AW_W ? aw_w_done :
          state == WR_B    ? m_axi_bvalid :
          state == RD_AR   ? m_axi_arready :
          state == RD_R    ? m_axi_rvalid : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_wr <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= 2'b00;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_araddr <= '0;
      m_axi_wdata <= '0;
      m_axi_wstrb <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          rsp_wr <= cmd_wr;
          rsp_rdata <= '0;
          rsp_resp <= 2'b00;
          m_axi_awaddr <= cmd_addr;
          m_axi_araddr <= cmd_addr;
          m_axi_wdata <= cmd_wdata;
          m_axi_wstrb <= cmd_wstrb;
          m_axi_awvalid <= cmd_wr;
          m_axi_wvalid <= cmd_wr;
          m_axi_arvalid <= !cmd_wr;
          cnt <= '0;
          state <= cmd_wr ? WR_AW_W : RD_AR;
        end
        WR_AW_W: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready) m_axi_wvalid <= 1'b0;
          if (aw_w_done) begin
            m_axi_bready <= 1'b1;
            cnt <= '0;
            state <= WR_B;
          end
        end
        WR_B: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          rsp_resp <= m_axi_bresp;
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RD_AR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready <= 1'b1;
          cnt <= '0;
          state <= RD_R;
        end
        RD_R: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          rsp_rdata <= m_axi_rdata;
          rsp_resp <= m_axi_rresp;
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // a handshake in the same cycle wins, so the timeout only acts on stalled cycles
      if (wait_st && !adv) begin
        if (tmo) begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid <= 1'b0;
          m_axi_bready <= 1'b0;
          m_axi_arvalid <= 1'b0;
          m_axi_rready <= 1'b0;
          rsp_rdata <= '0;
          rsp_resp <= 2'b11;
          rsp_valid <= 1'b1;
          state <= RSP;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_crf_axil_cfg_master.sv
// tb_crf_axil_cfg_master: random and directed commands against an AXI-Lite slave model, checked with a register-level reference model
module tb_crf_axil_cfg_master;
  localparam int TO = 16;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_wr = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0] cmd_wstrb = 0;
  logic rsp_valid, rsp_ready = 0, rsp_wr;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0] wstrb;
  logic [2:0] awprot, arprot;
  logic [1:0] bresp, rresp;

  crf_axil_cfg_master #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int b_skip = 0, r_skip = 0;
  bit b_never = 0, allow_drop = 0;
  logic [1:0] bresp_cfg = 0, rresp_cfg = 0;
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  logic [31:0] mem [16] = '{default: 32'h0};
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, bready_cyc = 0, arv_cyc = 0;
  logic [31:0] awa = 0, wd = 0, ara = 0, p_awaddr = 0, p_wdata = 0, p_araddr = 0;
  logic [3:0] ws = 0;
  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  int ac = 0, wc = 0, bc = 0, arc = 0, rc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave model: drives its outputs at negedge from the current DUT outputs
  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      ac = 0; wc = 0; bc = 0; arc = 0; rc = 0;
    end else begin
      if (awvalid) begin awready = ac >= aw_dly; if (ac < aw_dly) ac++; end else begin awready = 0; ac = 0; end
      if (wvalid) begin wready = wc >= w_dly; if (wc < w_dly) wc++; end else begin wready = 0; wc = 0; end
      if (arvalid) begin arready = arc >= ar_dly; if (arc < ar_dly) arc++; end else begin arready = 0; arc = 0; end
      if (!b_never && aw_hs > b_hs + b_skip && w_hs > b_hs + b_skip) begin
        bvalid = bc >= b_dly; bresp = bresp_cfg; if (bc < b_dly) bc++;
      end else begin bvalid = 0; bc = 0; end
      if (ar_hs > r_hs + r_skip) begin
        rvalid = rc >= r_dly; rresp = rresp_cfg; rdata = mem[ara[5:2]]; if (rc < r_dly) rc++;
      end else begin rvalid = 0; rc = 0; end
    end
  end

  // bus monitor: handshake counting, slave memory, and protocol rules
  always @(posedge clk) begin
    if (!rst) begin
      if (awvalid && awready) begin aw_hs <= aw_hs + 1; awa <= awaddr; end
      if (wvalid && wready) begin w_hs <= w_hs + 1; wd <= wdata; ws <= wstrb; end
      if (bvalid && bready) begin
        b_hs <= b_hs + 1;
        for (int i = 0; i < 4; i++) if (ws[i]) mem[awa[5:2]][8*i+:8] <= wd[8*i+:8];
      end
      if (arvalid && arready) begin ar_hs <= ar_hs + 1; ara <= araddr; end
      if (rvalid && rready) r_hs <= r_hs + 1;
      if (bready) bready_cyc <= bready_cyc + 1;
      if (arvalid) arv_cyc <= arv_cyc + 1;
      if (bready) chk("bready_before_aw_w_done", {awvalid, wvalid}, 2'b00);
      if (!allow_drop && p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (!allow_drop && p_wv && !p_wr) chk("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
      if (!allow_drop && p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
      p_wv <= wvalid; p_wr <= wready; p_wdata <= wdata;
      p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end
  end

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    chk("cmd_ready_drop", cmd_ready, 0);
    chk("first_valid", wr ? {awvalid, wvalid, arvalid} : {awvalid, wvalid, arvalid}, wr ? 3'b110 : 3'b001);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("rsp_arrive", rsp_valid, 1);
  endtask

  task automatic take_rsp(input int hold, input logic wr, input logic [31:0] er, input logic [1:0] ep);
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_wr", rsp_wr, wr);
      chk("rsp_rdata", rsp_rdata, er);
      chk("rsp_resp", rsp_resp, ep);
      chk("cmd_ready_busy", cmd_ready, 0);
      if (i < hold) @(negedge clk);
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  task automatic txn(input logic wr, input int idx, input logic [31:0] d, input logic [3:0] s, input bit tmo, input int hold);
    logic [31:0] er;
    logic [1:0] ep;
    int lat, el, mx;
    mx = aw_dly > w_dly ? aw_dly : w_dly;
    er = (wr || tmo) ? 32'h0 : ref_mem[idx];
    ep = tmo ? 2'b11 : wr ? bresp_cfg : rresp_cfg;
    el = tmo ? 2 + mx + TO : wr ? 3 + mx + b_dly : 3 + ar_dly + r_dly;
    send(wr, 32'(idx * 4), d, s);
    wait_rsp(lat);
    chk("latency", lat, el);
    take_rsp(hold, wr, er, ep);
    if (wr && !tmo) for (int i = 0; i < 4; i++) if (s[i]) ref_mem[idx][8*i+:8] = d[8*i+:8];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_aw, s_w, s_b, s_br, s_arv, lat;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    chk("rst_rsp", {rsp_wr, rsp_rdata, rsp_resp}, 35'h0);
    chk("rst_addr", {awaddr, araddr}, 64'h0);
    chk("rst_data", {wdata, wstrb}, 36'h0);
    chk("prot", {awprot, arprot}, 6'b0);
    rst = 0;
    @(negedge clk);

    s_aw = aw_hs; s_w = w_hs; s_b = b_hs; s_br = bready_cyc;
    txn(1, 1, 32'h1, 4'hF, 0, 0);
    chk("wr1_aw_beats", aw_hs - s_aw, 1);
    chk("wr1_w_beats", w_hs - s_w, 1);
    chk("wr1_b_beats", b_hs - s_b, 1);
    chk("wr1_bready_cycles", bready_cyc - s_br, 1);

    txn(1, 2, 32'hDEADBEEF, 4'hF, 0, 0);
    ar_dly = 4; s_arv = arv_cyc;
    txn(0, 2, 0, 0, 0, 0);
    chk("rd_arvalid_cycles", arv_cyc - s_arv, 5);
    chk("rd_model_value", ref_mem[2], 32'hDEADBEEF);
    ar_dly = 0;

    aw_dly = 4; w_dly = 0; s_b = b_hs; s_aw = aw_hs; s_w = w_hs;
    txn(1, 3, 32'h12345678, 4'hF, 0, 0);
    aw_dly = 0; w_dly = 4;
    txn(1, 4, 32'hA5A5A5A5, 4'h5, 0, 1);
    w_dly = 0;
    chk("split_b_beats", b_hs - s_b, 2);
    chk("split_aw_beats", aw_hs - s_aw, 2);
    chk("split_w_beats", w_hs - s_w, 2);
    txn(0, 3, 0, 0, 0, 0);
    txn(0, 4, 0, 0, 0, 0);

    bresp_cfg = 2'b10;
    txn(1, 5, 32'hCAFEF00D, 4'hC, 0, 0);
    rresp_cfg = 2'b11;
    txn(0, 5, 0, 0, 0, 0);
    bresp_cfg = 0; rresp_cfg = 0;

    b_never = 1; s_br = bready_cyc;
    txn(1, 6, 32'h55555555, 4'hF, 1, 0);
    chk("tmo_bready_cycles", bready_cyc - s_br, TO);
    chk("tmo_bready_low", bready, 0);
    b_never = 0; b_skip++;
    txn(0, 6, 0, 0, 0, 0);

    send(0, 32'(5 * 4), 0, 0);
    wait_rsp(lat);
    chk("hold_latency", lat, 3);
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 32'(7 * 4);
    for (int i = 0; i < 10; i++) begin
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp", {rsp_valid, rsp_wr, rsp_rdata, rsp_resp}, {1'b1, 1'b0, ref_mem[5], 2'b00});
      @(negedge clk);
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    chk("hold_cmd_ready_back", cmd_ready, 1);
    chk("hold_idle", {rsp_valid, arvalid}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    chk("second_started", {cmd_ready, arvalid}, 2'b01);
    wait_rsp(lat);
    chk("second_latency", lat, 3);
    take_rsp(0, 0, ref_mem[7], 2'b00);

    r_dly = 30;
    send(0, 32'(2 * 4), 0, 0);
    lat = 0;
    while (!rready && lat < 50) begin @(negedge clk); lat++; end
    chk("reached_rd_r", rready, 1);
    allow_drop = 1; rst = 1; r_skip++;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valids", {arvalid, rready, rsp_valid}, 3'b000);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_rsp", {rsp_rdata, rsp_resp}, 34'h0);
    rst = 0; r_dly = 0; seen = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid) seen = 1; end
    chk("no_rsp_after_rst", seen, 0);
    allow_drop = 0;
    txn(0, 2, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom); rresp_cfg = 2'($urandom);
      txn(1'($urandom), int'($urandom_range(0, 15)), $urandom, 4'($urandom), 0, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
